// File: rtl/quadrant_dispatch_ctrl.sv
`default_nettype none
// =====================================================================
// Module : quadrant_dispatch_ctrl
// Keypad quadrant select/confirm, request FIFO and start/done dispatch.
// Option : QDISPATCH_DEDUP_EN discards confirms already queued/in service.
// Rev    : 1.0
// =====================================================================
module quadrant_dispatch_ctrl #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 10_000_000,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_valid,
    input  logic [3:0]    key_quadrant,
    input  logic          key_is_confirm,
    input  logic          key_is_cancel,
    input  logic          proc_done,
    output logic [15:0]   sel_led,
    output logic          sel_armed,
    output logic          proc_start,
    output logic [3:0]    proc_quadrant,
    output logic          busy,
    output logic [CW-1:0] queue_count,
    output logic          drop
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [TW-1:0] c_TLAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] c_TMAX  = {TW{1'b1}};
    localparam logic [CW-1:0] c_FULL  = CW'(DEPTH);

    localparam logic [0:0] c_SEL_IDLE  = 1'b0;
    localparam logic [0:0] c_SEL_ARMED = 1'b1;
    localparam logic [0:0] c_D_IDLE    = 1'b0;
    localparam logic [0:0] c_D_WAIT    = 1'b1;

    logic [0:0]    r_sel_state, w_sel_nxt;
    logic [0:0]    r_d_state,   w_d_nxt;
    logic [TW-1:0] r_timer,     w_timer_nxt;
    logic [3:0]    r_sel_idx,   w_idx_nxt;
    logic [15:0]   r_sel_led,   w_led_nxt;
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count,     w_count_nxt;
    logic          r_start, r_drop, w_drop_nxt;
    logic [3:0]    r_quad,      w_quad_nxt;
    logic [3:0]    r_mem [DEPTH];

    logic w_ev_cancel, w_ev_confirm, w_ev_digit;
    logic w_push_req, w_push_ok, w_push, w_pop, w_full, w_dup;

    // Cancel outranks confirm, which outranks a digit.
    assign w_ev_cancel  = key_valid & key_is_cancel;
    assign w_ev_confirm = key_valid & key_is_confirm & ~key_is_cancel;
    assign w_ev_digit   = key_valid & ~key_is_confirm & ~key_is_cancel;

    assign w_full     = (r_count == c_FULL);
    assign w_pop      = (r_d_state == c_D_IDLE) && (r_count != '0);
    assign w_push_req = (r_sel_state == c_SEL_ARMED) && w_ev_confirm;

`ifdef QDISPATCH_DEDUP_EN
    always_comb begin
        logic [PW-1:0] off;
        w_dup = (r_d_state == c_D_WAIT) && (r_quad == r_sel_idx);
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - r_rd_ptr;
            if ((CW'(off) < r_count) && (r_mem[i] == r_sel_idx))
                w_dup = 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_state <= c_SEL_IDLE;
            r_d_state   <= c_D_IDLE;
            r_timer     <= '0;
            r_sel_idx   <= '0;
            r_sel_led   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_start     <= 1'b0;
            r_quad      <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_sel_state <= w_sel_nxt;
            r_d_state   <= w_d_nxt;
            r_timer     <= w_timer_nxt;
            r_sel_idx   <= w_idx_nxt;
            r_sel_led   <= w_led_nxt;
            r_count     <= w_count_nxt;
            r_start     <= w_pop;
            r_quad      <= w_quad_nxt;
            r_drop      <= w_drop_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_sel_idx;
    end

    // Next-state logic
    always_comb begin
        w_sel_nxt = r_sel_state;
        case (r_sel_state)
            c_SEL_IDLE: begin
                if (w_ev_digit) w_sel_nxt = c_SEL_ARMED;
            end
            c_SEL_ARMED: begin
                if (w_ev_cancel || w_ev_confirm) w_sel_nxt = c_SEL_IDLE;
                else if (w_ev_digit)             w_sel_nxt = c_SEL_ARMED;
                else if (r_timer == c_TLAST)     w_sel_nxt = c_SEL_IDLE;
            end
            default: w_sel_nxt = c_SEL_IDLE;
        endcase

        w_d_nxt = r_d_state;
        case (r_d_state)
            c_D_IDLE: if (w_pop)     w_d_nxt = c_D_WAIT;
            c_D_WAIT: if (proc_done) w_d_nxt = c_D_IDLE;
            default:                 w_d_nxt = c_D_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_timer_nxt = '0;
        if (r_sel_state == c_SEL_ARMED && !key_valid)
            w_timer_nxt = (r_timer == c_TMAX) ? r_timer : r_timer + 1'b1;

        w_idx_nxt = w_ev_digit ? key_quadrant : r_sel_idx;
        w_led_nxt = (w_sel_nxt == c_SEL_ARMED) ? (16'h0001 << w_idx_nxt) : 16'h0000;

        w_push_ok  = w_push_req && !w_dup;
        w_push     = w_push_ok && (!w_full || w_pop);
        w_drop_nxt = w_push_ok && w_full && !w_pop;

        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;

        w_quad_nxt = w_pop ? r_mem[r_rd_ptr] : r_quad;
    end

    assign sel_led       = r_sel_led;
    assign sel_armed     = (r_sel_state == c_SEL_ARMED);
    assign proc_start    = r_start;
    assign proc_quadrant = r_quad;
    assign busy          = (r_d_state == c_D_WAIT);
    assign queue_count   = r_count;
    assign drop          = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_quadrant_dispatch_ctrl.sv
`default_nettype none
// Directed testbench for quadrant_dispatch_ctrl (DEPTH=4, TIMEOUT_CYC=16).
module tb_quadrant_dispatch_ctrl;

    localparam int DEPTH = 4;
    localparam int TOUT  = 16;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef QDISPATCH_DEDUP_EN
    localparam int DEDUP = 1;
`else
    localparam int DEDUP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_valid, key_is_confirm, key_is_cancel, proc_done;
    logic [3:0]    key_quadrant;
    logic [15:0]   sel_led;
    logic          sel_armed, proc_start, busy, drop;
    logic [3:0]    proc_quadrant;
    logic [CW-1:0] queue_count;

    int n_checks = 0;
    int n_fail   = 0;

    quadrant_dispatch_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_quadrant(key_quadrant),
        .key_is_confirm(key_is_confirm), .key_is_cancel(key_is_cancel),
        .proc_done(proc_done),
        .sel_led(sel_led), .sel_armed(sel_armed),
        .proc_start(proc_start), .proc_quadrant(proc_quadrant),
        .busy(busy), .queue_count(queue_count), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key_event(input logic [3:0] q, input logic conf, input logic canc);
        key_valid      = 1'b1;
        key_quadrant   = q;
        key_is_confirm = conf;
        key_is_cancel  = canc;
        tick();
        key_valid      = 1'b0;
        key_is_confirm = 1'b0;
        key_is_cancel  = 1'b0;
        key_quadrant   = 4'd0;
    endtask

    task automatic done_pulse();
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
    endtask

    task automatic select_confirm(input logic [3:0] q);
        key_event(q, 1'b0, 1'b0);
        key_event(4'd0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] drain_q [4];
        drain_q = '{4'd3, 4'd4, 4'd5, 4'd7};

        rst_n = 1'b0; key_valid = 1'b0; key_quadrant = 4'd0;
        key_is_confirm = 1'b0; key_is_cancel = 1'b0; proc_done = 1'b0;
        tick(); tick();
        check_eq("rst_sel_led", 32'(sel_led), 32'h0);
        check_eq("rst_armed",   32'(sel_armed), 32'h0);
        check_eq("rst_start",   32'(proc_start), 32'h0);
        check_eq("rst_busy",    32'(busy), 32'h0);
        check_eq("rst_count",   32'(queue_count), 32'h0);
        check_eq("rst_drop",    32'(drop), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic flow: digit 5 at N, confirm at N+3
        key_event(4'd5, 1'b0, 1'b0);
        check_eq("basic_led",   32'(sel_led), 32'h0020);
        check_eq("basic_armed", 32'(sel_armed), 32'h1);
        tick(); tick();
        key_event(4'd0, 1'b1, 1'b0);
        check_eq("basic_count1", 32'(queue_count), 32'h1);
        check_eq("basic_nostart", 32'(proc_start), 32'h0);
        check_eq("basic_disarm", 32'(sel_armed), 32'h0);
        tick();
        check_eq("basic_start", 32'(proc_start), 32'h1);
        check_eq("basic_quad",  32'(proc_quadrant), 32'h5);
        check_eq("basic_busy",  32'(busy), 32'h1);
        check_eq("basic_count0", 32'(queue_count), 32'h0);
        tick();
        check_eq("basic_start_pulse", 32'(proc_start), 32'h0);
        check_eq("basic_busy_hold", 32'(busy), 32'h1);
        done_pulse();
        check_eq("basic_busy_clr", 32'(busy), 32'h0);
        check_eq("basic_quad_hold", 32'(proc_quadrant), 32'h5);
        tick();
        check_eq("basic_no_restart", 32'(proc_start), 32'h0);

        // Overflow: 1 dispatched, 2..5 queued, 6 dropped
        for (int q = 1; q <= 6; q++) select_confirm(4'(q));
        check_eq("ovf_drop",  32'(drop), 32'h1);
        check_eq("ovf_count", 32'(queue_count), 32'h4);
        tick();
        check_eq("ovf_drop_pulse", 32'(drop), 32'h0);
        check_eq("ovf_quad", 32'(proc_quadrant), 32'h1);
        check_eq("ovf_busy", 32'(busy), 32'h1);

        // Push and pop together at full
        key_event(4'd7, 1'b0, 1'b0);
        done_pulse();
        check_eq("full_busy_clr", 32'(busy), 32'h0);
        check_eq("full_count", 32'(queue_count), 32'h4);
        key_event(4'd0, 1'b1, 1'b0);
        check_eq("full_pp_start", 32'(proc_start), 32'h1);
        check_eq("full_pp_quad",  32'(proc_quadrant), 32'h2);
        check_eq("full_pp_drop",  32'(drop), 32'h0);
        check_eq("full_pp_count", 32'(queue_count), 32'h4);
        for (int i = 0; i < 4; i++) begin
            done_pulse();
            tick();
            check_eq("drain_start", 32'(proc_start), 32'h1);
            check_eq("drain_quad",  32'(proc_quadrant), 32'(drain_q[i]));
        end
        check_eq("drain_count", 32'(queue_count), 32'h0);
        done_pulse();
        check_eq("drain_idle", 32'(busy), 32'h0);

        // Timeout
        key_event(4'd9, 1'b0, 1'b0);
        check_eq("to_armed", 32'(sel_armed), 32'h1);
        check_eq("to_led",   32'(sel_led), 32'h0200);
        for (int i = 1; i < TOUT; i++) tick();
        check_eq("to_still_armed", 32'(sel_armed), 32'h1);
        tick();
        check_eq("to_expired", 32'(sel_armed), 32'h0);
        check_eq("to_led_clr", 32'(sel_led), 32'h0);
        key_event(4'd0, 1'b1, 1'b0);
        check_eq("to_no_push", 32'(queue_count), 32'h0);
        tick();
        check_eq("to_no_start", 32'(proc_start), 32'h0);

        // Cancel outranks confirm; reselect before confirm
        key_event(4'd3, 1'b0, 1'b0);
        key_event(4'd0, 1'b1, 1'b1);
        check_eq("cancel_idle",  32'(sel_armed), 32'h0);
        check_eq("cancel_count", 32'(queue_count), 32'h0);
        key_event(4'd7, 1'b0, 1'b0);
        key_event(4'd2, 1'b0, 1'b0);
        check_eq("resel_led", 32'(sel_led), 32'h0004);
        key_event(4'd0, 1'b1, 1'b0);
        check_eq("resel_count", 32'(queue_count), 32'h1);
        tick();
        check_eq("resel_quad", 32'(proc_quadrant), 32'h2);
        done_pulse();

        // Duplicate confirms while busy on 4
        select_confirm(4'd4);
        tick();
        check_eq("dup_busy", 32'(busy), 32'h1);
        select_confirm(4'd4);
        check_eq("dup_count1", 32'(queue_count), 32'(DEDUP ? 0 : 1));
        check_eq("dup_drop1",  32'(drop), 32'h0);
        select_confirm(4'd4);
        check_eq("dup_count2", 32'(queue_count), 32'(DEDUP ? 0 : 2));
        check_eq("dup_drop2",  32'(drop), 32'h0);
        for (int i = 0; i < 8 && (busy || queue_count != 0); i++) begin
            done_pulse();
            tick();
        end
        check_eq("dup_drained", 32'(queue_count), 32'h0);
        check_eq("dup_idle",    32'(busy), 32'h0);

        // Reset mid-service with 3 queued
        for (int q = 10; q <= 13; q++) select_confirm(4'(q));
        key_event(4'd14, 1'b0, 1'b0);
        check_eq("pre_rst_count", 32'(queue_count), 32'h3);
        check_eq("pre_rst_busy",  32'(busy), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_rst_led",   32'(sel_led), 32'h0);
        check_eq("mid_rst_armed", 32'(sel_armed), 32'h0);
        check_eq("mid_rst_busy",  32'(busy), 32'h0);
        check_eq("mid_rst_count", 32'(queue_count), 32'h0);
        check_eq("mid_rst_quad",  32'(proc_quadrant), 32'h0);
        check_eq("mid_rst_start", 32'(proc_start), 32'h0);
        done_pulse();
        check_eq("post_rst_done_busy", 32'(busy), 32'h0);
        tick();
        check_eq("post_rst_no_start", 32'(proc_start), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
